// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, field
// positions, WARL write masks, interrupt cause codes and op encodings.
package csr_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  // mstatus fields
  localparam int unsigned MSTATUS_MIE_BIT   = 3;
  localparam int unsigned MSTATUS_MPIE_BIT  = 7;
  localparam logic [31:0] MSTATUS_MPP_BITS  = 32'h0000_1800;

  // mip / mie fields
  localparam int unsigned MIP_MSIP_BIT      = 3;
  localparam int unsigned MIP_MTIP_BIT      = 7;
  localparam int unsigned MIP_MEIP_BIT      = 11;

  // mcountinhibit fields
  localparam int unsigned MCOUNTINHIBIT_CY_BIT = 0;
  localparam int unsigned MCOUNTINHIBIT_IR_BIT = 2;

  // WARL write masks
  localparam logic [31:0] MTVEC_WMASK         = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_WMASK          = 32'hFFFF_FFFC;
  localparam logic [31:0] MIE_WMASK           = 32'h0000_0888;
  localparam logic [31:0] MCOUNTINHIBIT_WMASK = 32'h0000_0005;

  // Interrupt cause codes
  localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
  localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
  localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

  // funct3[1:0] encodings
  typedef enum logic [1:0] {
    CSR_OP_ILL = 2'b00,
    CSR_OP_RW  = 2'b01,
    CSR_OP_RS  = 2'b10,
    CSR_OP_RC  = 2'b11
  } csr_op_e;

  // Addresses with [11:10] = 2'b11 are read-only
  function automatic logic csr_is_read_only(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// Free-running counter with inhibit and split low/high-half writes.
// A write to either half replaces the increment for the whole counter.
module csr_counter64
  import csr_pkg::*;
#(
  parameter int unsigned CNT_W = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               inc_i,
  input  logic               inhibit_i,
  input  logic               wr_lo_i,
  input  logic               wr_hi_i,
  input  logic [CNT_W/2-1:0] wdata_i,
  output logic [CNT_W-1:0]   count_o
);

  logic [CNT_W-1:0] count_q;

  // Half writes take priority; otherwise full-width increment carries low to high
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (wr_lo_i) begin
      count_q[CNT_W/2-1:0] <= wdata_i;
    end else if (wr_hi_i) begin
      count_q[CNT_W-1:CNT_W/2] <= wdata_i;
    end else if (inc_i && !inhibit_i) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: registered CSR access with WARL masking,
// cycle/instret counters, trap entry / mret sequencing and interrupt
// arbitration.
module csr_unit
  import csr_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter int unsigned CNT_W       = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            csr_req_i,
  input  logic [2:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  input  logic            csr_src_zero_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_rvalid_o,
  output logic            csr_illegal_o,
  input  logic            retire_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic            mret_i,
  input  logic            irq_ext_i,
  input  logic            irq_tim_i,
  input  logic            irq_sw_i,
  output logic            irq_take_o,
  output logic [XLEN-1:0] irq_cause_o,
  output logic [XLEN-1:0] trap_vec_o,
  output logic [XLEN-1:0] mepc_o
);

  csr_op_e         op;
  logic            unused_op_imm;
  logic            mstatus_mie, mstatus_mpie;
  logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0] mie_q, mip_q, mcountinhibit_q, irq_lines;
  logic [XLEN-1:0] rdata_q;
  logic            rvalid_q, illegal_q;
  logic [CNT_W-1:0] mcycle, minstret;

  logic [XLEN-1:0] rd_val, wr_val;
  logic            addr_ok, wr_attempt, legal, accept, do_write;
  logic            we_mstatus, we_mtvec, we_mscratch, we_mepc, we_mcause;
  logic            we_mtval, we_mie, we_mcountinhibit;
  logic            we_mcycle, we_mcycleh, we_minstret, we_minstreth;

  // funct3[2] only selects rs1 vs uimm, which arrives already resolved on wdata
  assign op            = csr_op_e'(csr_op_i[1:0]);
  assign unused_op_imm = csr_op_i[2];

  // Read mux and address decode
  always_comb begin
    rd_val  = '0;
    addr_ok = 1'b1;
    case (csr_addr_i)
      CSR_MISA:      rd_val = MISA_VAL;
      CSR_MVENDORID,
      CSR_MARCHID,
      CSR_MIMPID:    rd_val = '0;
      CSR_MHARTID:   rd_val = HART_ID;
      CSR_MSTATUS: begin
        rd_val                   = MSTATUS_MPP_BITS;
        rd_val[MSTATUS_MIE_BIT]  = mstatus_mie;
        rd_val[MSTATUS_MPIE_BIT] = mstatus_mpie;
      end
      CSR_MTVEC:         rd_val = mtvec_q;
      CSR_MSCRATCH:      rd_val = mscratch_q;
      CSR_MEPC:          rd_val = mepc_q;
      CSR_MCAUSE:        rd_val = mcause_q;
      CSR_MTVAL:         rd_val = mtval_q;
      CSR_MIE:           rd_val = mie_q;
      CSR_MIP:           rd_val = mip_q;
      CSR_MCOUNTINHIBIT: rd_val = mcountinhibit_q;
      CSR_MCYCLE:        rd_val = mcycle[XLEN-1:0];
      CSR_MCYCLEH:       rd_val = mcycle[CNT_W-1 -: XLEN];
      CSR_MINSTRET:      rd_val = minstret[XLEN-1:0];
      CSR_MINSTRETH:     rd_val = minstret[CNT_W-1 -: XLEN];
      default:           addr_ok = 1'b0;
    endcase
  end

  // New value for the addressed CSR before per-register WARL masking
  always_comb begin
    wr_val = '0;
    case (op)
      CSR_OP_RW: wr_val = csr_wdata_i;
      CSR_OP_RS: wr_val = rd_val | csr_wdata_i;
      CSR_OP_RC: wr_val = rd_val & ~csr_wdata_i;
      default:   wr_val = '0;
    endcase
  end

  assign wr_attempt = (op == CSR_OP_RW) || !csr_src_zero_i;
  assign legal      = addr_ok && (op != CSR_OP_ILL) &&
                      !(wr_attempt && csr_is_read_only(csr_addr_i));
  assign accept     = csr_req_i && !trap_i;
  assign do_write   = accept && legal && wr_attempt;

  assign we_mstatus       = do_write && (csr_addr_i == CSR_MSTATUS);
  assign we_mtvec         = do_write && (csr_addr_i == CSR_MTVEC);
  assign we_mscratch      = do_write && (csr_addr_i == CSR_MSCRATCH);
  assign we_mepc          = do_write && (csr_addr_i == CSR_MEPC);
  assign we_mcause        = do_write && (csr_addr_i == CSR_MCAUSE);
  assign we_mtval         = do_write && (csr_addr_i == CSR_MTVAL);
  assign we_mie           = do_write && (csr_addr_i == CSR_MIE);
  assign we_mcountinhibit = do_write && (csr_addr_i == CSR_MCOUNTINHIBIT);
  assign we_mcycle        = do_write && (csr_addr_i == CSR_MCYCLE);
  assign we_mcycleh       = do_write && (csr_addr_i == CSR_MCYCLEH);
  assign we_minstret      = do_write && (csr_addr_i == CSR_MINSTRET);
  assign we_minstreth     = do_write && (csr_addr_i == CSR_MINSTRETH);

  // Raw interrupt lines placed at their mip bit positions
  always_comb begin
    irq_lines               = '0;
    irq_lines[MIP_MEIP_BIT] = irq_ext_i;
    irq_lines[MIP_MTIP_BIT] = irq_tim_i;
    irq_lines[MIP_MSIP_BIT] = irq_sw_i;
  end

  // Architectural state: trap entry first, then mret, then CSR writes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mstatus_mie     <= 1'b0;
      mstatus_mpie    <= 1'b0;
      mtvec_q         <= RESET_MTVEC & MTVEC_WMASK;
      mscratch_q      <= '0;
      mepc_q          <= '0;
      mcause_q        <= '0;
      mtval_q         <= '0;
      mie_q           <= '0;
      mip_q           <= '0;
      mcountinhibit_q <= '0;
    end else begin
      mip_q <= irq_lines;
      if (trap_i) begin
        mepc_q       <= trap_pc_i & MEPC_WMASK;
        mcause_q     <= trap_cause_i;
        mtval_q      <= trap_tval_i;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else begin
        // mret owns mstatus; a coincident CSR write still lands elsewhere
        if (mret_i) begin
          mstatus_mie  <= mstatus_mpie;
          mstatus_mpie <= 1'b1;
        end else if (we_mstatus) begin
          mstatus_mie  <= wr_val[MSTATUS_MIE_BIT];
          mstatus_mpie <= wr_val[MSTATUS_MPIE_BIT];
        end
        if (we_mtvec)         mtvec_q         <= wr_val & MTVEC_WMASK;
        if (we_mscratch)      mscratch_q      <= wr_val;
        if (we_mepc)          mepc_q          <= wr_val & MEPC_WMASK;
        if (we_mcause)        mcause_q        <= wr_val;
        if (we_mtval)         mtval_q         <= wr_val;
        if (we_mie)           mie_q           <= wr_val & MIE_WMASK;
        if (we_mcountinhibit) mcountinhibit_q <= wr_val & MCOUNTINHIBIT_WMASK;
      end
    end
  end

  // Registered read response; illegal or squashed accesses return zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      rvalid_q  <= accept;
      illegal_q <= accept && !legal;
      rdata_q   <= (accept && legal) ? rd_val : '0;
    end
  end

  csr_counter64 #(.CNT_W(CNT_W)) u_mcycle (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .inc_i     (1'b1),
    .inhibit_i (mcountinhibit_q[MCOUNTINHIBIT_CY_BIT]),
    .wr_lo_i   (we_mcycle),
    .wr_hi_i   (we_mcycleh),
    .wdata_i   (wr_val),
    .count_o   (mcycle)
  );

  csr_counter64 #(.CNT_W(CNT_W)) u_minstret (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .inc_i     (retire_i),
    .inhibit_i (mcountinhibit_q[MCOUNTINHIBIT_IR_BIT]),
    .wr_lo_i   (we_minstret),
    .wr_hi_i   (we_minstreth),
    .wdata_i   (wr_val),
    .count_o   (minstret)
  );

  // Interrupt arbitration: MEI > MSI > MTI, gated by mstatus.MIE
  always_comb begin
    logic [XLEN-1:0] pend;
    logic [3:0]      code;
    pend = mip_q & mie_q;
    code = '0;
    if (pend[MIP_MEIP_BIT])      code = IRQ_CODE_MEI;
    else if (pend[MIP_MSIP_BIT]) code = IRQ_CODE_MSI;
    else if (pend[MIP_MTIP_BIT]) code = IRQ_CODE_MTI;
    irq_take_o  = mstatus_mie && (|pend);
    irq_cause_o = irq_take_o ? {1'b1, 27'b0, code} : '0;
  end

  // Trap target: direct base, or vectored offset for interrupt causes
  always_comb begin
    logic [XLEN-1:0] base;
    base       = {mtvec_q[XLEN-1:2], 2'b00};
    trap_vec_o = base;
    if (mtvec_q[0] && trap_cause_i[XLEN-1]) begin
      trap_vec_o = base + {25'b0, trap_cause_i[4:0], 2'b00};
    end
  end

  assign csr_rdata_o   = rdata_q;
  assign csr_rvalid_o  = rvalid_q;
  assign csr_illegal_o = illegal_q;
  assign mepc_o        = mepc_q;

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: directed CSR accesses push expected responses into a
// queue that a negedge monitor drains whenever rvalid is seen; side-band
// outputs are compared directly.
module tb_csr_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        csr_req_i = 1'b0;
  logic [2:0]  csr_op_i = '0;
  logic [11:0] csr_addr_i = '0;
  logic [31:0] csr_wdata_i = '0;
  logic        csr_src_zero_i = 1'b0;
  logic [31:0] csr_rdata_o;
  logic        csr_rvalid_o;
  logic        csr_illegal_o;
  logic        retire_i = 1'b0;
  logic        trap_i = 1'b0;
  logic [31:0] trap_cause_i = '0;
  logic [31:0] trap_pc_i = '0;
  logic [31:0] trap_tval_i = '0;
  logic        mret_i = 1'b0;
  logic        irq_ext_i = 1'b0;
  logic        irq_tim_i = 1'b0;
  logic        irq_sw_i = 1'b0;
  logic        irq_take_o;
  logic [31:0] irq_cause_o;
  logic [31:0] trap_vec_o;
  logic [31:0] mepc_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] rdata;
    logic [31:0] mask;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];

  csr_unit #(
    .XLEN        (32),
    .HART_ID     (32'd0),
    .MISA_VAL    (32'h4000_0100),
    .RESET_MTVEC (32'h0000_0000),
    .CNT_W       (64)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .csr_req_i      (csr_req_i),
    .csr_op_i       (csr_op_i),
    .csr_addr_i     (csr_addr_i),
    .csr_wdata_i    (csr_wdata_i),
    .csr_src_zero_i (csr_src_zero_i),
    .csr_rdata_o    (csr_rdata_o),
    .csr_rvalid_o   (csr_rvalid_o),
    .csr_illegal_o  (csr_illegal_o),
    .retire_i       (retire_i),
    .trap_i         (trap_i),
    .trap_cause_i   (trap_cause_i),
    .trap_pc_i      (trap_pc_i),
    .trap_tval_i    (trap_tval_i),
    .mret_i         (mret_i),
    .irq_ext_i      (irq_ext_i),
    .irq_tim_i      (irq_tim_i),
    .irq_sw_i       (irq_sw_i),
    .irq_take_o     (irq_take_o),
    .irq_cause_o    (irq_cause_o),
    .trap_vec_o     (trap_vec_o),
    .mepc_o         (mepc_o)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: every rvalid must match the oldest outstanding expectation
  always @(negedge clk_i) begin
    if (rst_ni && csr_rvalid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected got rdata %h illegal %0b required no response",
                 csr_rdata_o, csr_illegal_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ((((csr_rdata_o ^ e.rdata) & e.mask) != 0) || (csr_illegal_o !== e.ill)) begin
          errors++;
          $display("FAIL resp_%h got rdata %h illegal %0b required rdata %h (mask %h) illegal %0b",
                   e.addr, csr_rdata_o, csr_illegal_o, e.rdata, e.mask, e.ill);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, req);
    end
  endtask

  // Issue one CSR request for one cycle; optionally expect a response
  task automatic csr(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wd,
                     input logic sz, input logic [31:0] er, input logic [31:0] em,
                     input logic ei, input logic expect_resp);
    exp_t e;
    csr_req_i      = 1'b1;
    csr_op_i       = op;
    csr_addr_i     = addr;
    csr_wdata_i    = wd;
    csr_src_zero_i = sz;
    if (expect_resp) begin
      e.addr  = addr;
      e.rdata = er;
      e.mask  = em;
      e.ill   = ei;
      exp_q.push_back(e);
    end
    @(posedge clk_i); #1;
    csr_req_i      = 1'b0;
    csr_op_i       = '0;
    csr_addr_i     = '0;
    csr_wdata_i    = '0;
    csr_src_zero_i = 1'b0;
  endtask

  task automatic rw(input logic [11:0] addr, input logic [31:0] wd, input logic [31:0] er);
    csr(3'b001, addr, wd, 1'b0, er, 32'hFFFF_FFFF, 1'b0, 1'b1);
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] er);
    csr(3'b010, addr, 32'h0, 1'b1, er, 32'hFFFF_FFFF, 1'b0, 1'b1);
  endtask

  task automatic ill(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wd,
                     input logic sz);
    csr(op, addr, wd, sz, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b1);
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Reset state
    cyc(2);
    chk("reset_rdata", csr_rdata_o, 32'h0);
    chk("reset_rvalid", {31'b0, csr_rvalid_o}, 32'h0);
    chk("reset_illegal", {31'b0, csr_illegal_o}, 32'h0);
    chk("reset_irq_take", {31'b0, irq_take_o}, 32'h0);
    chk("reset_irq_cause", irq_cause_o, 32'h0);
    chk("reset_trap_vec", trap_vec_o, 32'h0);
    chk("reset_mepc", mepc_o, 32'h0);
    @(negedge clk_i) rst_ni = 1'b1;
    cyc(1);

    // mscratch read/write and write suppression
    rw(12'h340, 32'hDEAD_BEEF, 32'h0);
    chk("rvalid_pulse_hi", {31'b0, csr_rvalid_o}, 32'h1);
    cyc(1);
    chk("rvalid_pulse_lo", {31'b0, csr_rvalid_o}, 32'h0);
    rd(12'h340, 32'hDEAD_BEEF);
    csr(3'b011, 12'h340, 32'hFFFF_FFFF, 1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    rd(12'h340, 32'hDEAD_BEEF);

    // Illegal accesses
    ill(3'b001, 12'hF11, 32'h5, 1'b0);
    rd(12'hF11, 32'h0);
    ill(3'b010, 12'hF11, 32'h1, 1'b0);
    ill(3'b001, 12'h7C0, 32'h5, 1'b0);
    ill(3'b000, 12'h340, 32'h0, 1'b0);
    ill(3'b100, 12'h340, 32'h1, 1'b0);
    rd(12'h340, 32'hDEAD_BEEF);
    rd(12'h301, 32'h4000_0100);
    rd(12'hF14, 32'h0);

    // Immediate form and clear
    csr(3'b101, 12'h340, 32'h1F, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    rw(12'h340, 32'hDEAD_BEEF, 32'h1F);
    csr(3'b011, 12'h340, 32'hF, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    rd(12'h340, 32'hDEAD_BEE0);

    // mcycle carry into high half, then freeze
    rw(12'h320, 32'h1, 32'h0);
    rw(12'hB80, 32'h0, 32'h0);
    csr(3'b001, 12'hB00, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    rd(12'hB00, 32'hFFFF_FFFF);
    rw(12'h320, 32'h0, 32'h1);
    rw(12'h320, 32'h1, 32'h0);
    rd(12'hB80, 32'h1);
    rd(12'hB00, 32'h0);
    cyc(3);
    rd(12'hB00, 32'h0);

    // minstret counting and write-over-retire
    rw(12'hB02, 32'h5, 32'h0);
    retire_i = 1'b1;
    cyc(3);
    retire_i = 1'b0;
    rd(12'hB02, 32'h8);
    retire_i = 1'b1;
    rw(12'hB02, 32'h64, 32'h8);
    retire_i = 1'b0;
    rd(12'hB02, 32'h64);
    rd(12'hB82, 32'h0);

    // WARL masks
    rw(12'h300, 32'hFFFF_FFFF, 32'h0000_1800);
    rd(12'h300, 32'h0000_1888);
    rw(12'h305, 32'h103, 32'h0);
    rd(12'h305, 32'h101);
    rw(12'h341, 32'h207, 32'h0);
    rd(12'h341, 32'h204);
    chk("mepc_o_warl", mepc_o, 32'h204);
    rw(12'h304, 32'hFFFF_FFFF, 32'h0);
    rd(12'h304, 32'h888);
    rw(12'h344, 32'hFFFF_FFFF, 32'h0);
    rd(12'h344, 32'h0);

    // Trap entry and mret
    rw(12'h300, 32'h8, 32'h0000_1888);
    rw(12'h305, 32'h100, 32'h101);
    trap_cause_i = 32'h2;
    trap_pc_i    = 32'h103;
    trap_tval_i  = 32'h55;
    trap_i       = 1'b1;
    chk("trap_vec_direct", trap_vec_o, 32'h100);
    cyc(1);
    trap_i = 1'b0;
    chk("trap_mepc", mepc_o, 32'h100);
    rd(12'h300, 32'h0000_1880);
    rd(12'h342, 32'h2);
    rd(12'h343, 32'h55);
    mret_i = 1'b1;
    cyc(1);
    mret_i = 1'b0;
    rd(12'h300, 32'h0000_1888);

    // Interrupt arbitration and vectored trap target
    rw(12'h305, 32'h101, 32'h100);
    irq_tim_i = 1'b1;
    irq_ext_i = 1'b1;
    chk("irq_latency", {31'b0, irq_take_o}, 32'h0);
    cyc(1);
    chk("irq_take_ext", {31'b0, irq_take_o}, 32'h1);
    chk("irq_cause_ext", irq_cause_o, 32'h8000_000B);
    irq_ext_i = 1'b0;
    cyc(1);
    chk("irq_cause_tim", irq_cause_o, 32'h8000_0007);
    irq_sw_i = 1'b1;
    cyc(1);
    chk("irq_cause_sw", irq_cause_o, 32'h8000_0003);
    irq_ext_i = 1'b1;
    cyc(1);
    chk("irq_cause_ext2", irq_cause_o, 32'h8000_000B);
    trap_cause_i = 32'h8000_000B;
    #1;
    chk("trap_vec_vectored", trap_vec_o, 32'h12C);
    trap_cause_i = 32'h2;
    #1;
    chk("trap_vec_exc_base", trap_vec_o, 32'h100);

    // CSR request squashed by a coincident trap
    trap_cause_i = 32'h8000_000B;
    trap_pc_i    = 32'h40;
    trap_tval_i  = 32'h0;
    trap_i       = 1'b1;
    csr(3'b001, 12'h340, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    trap_i = 1'b0;
    chk("squash_rvalid", {31'b0, csr_rvalid_o}, 32'h0);
    chk("trap_irq_masked", {31'b0, irq_take_o}, 32'h0);
    chk("trap_irq_cause0", irq_cause_o, 32'h0);
    chk("trap_mepc2", mepc_o, 32'h40);
    rd(12'h340, 32'hDEAD_BEE0);

    // mret owns mstatus over a coincident CSR write
    mret_i = 1'b1;
    rw(12'h300, 32'h0, 32'h0000_1880);
    mret_i = 1'b0;
    rd(12'h300, 32'h0000_1888);
    chk("mret_irq_take", {31'b0, irq_take_o}, 32'h1);

    // Asynchronous reset mid-run
    csr(3'b010, 12'h340, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    #1 rst_ni = 1'b0;
    #1;
    chk("areset_rvalid", {31'b0, csr_rvalid_o}, 32'h0);
    chk("areset_rdata", csr_rdata_o, 32'h0);
    chk("areset_irq_take", {31'b0, irq_take_o}, 32'h0);
    chk("areset_irq_cause", irq_cause_o, 32'h0);
    chk("areset_trap_vec", trap_vec_o, 32'h0);
    chk("areset_mepc", mepc_o, 32'h0);
    @(negedge clk_i) rst_ni = 1'b1;
    cyc(1);
    rd(12'h340, 32'h0);
    rd(12'h300, 32'h0000_1800);
    rd(12'h305, 32'h0);
    rd(12'h304, 32'h0);
    rd(12'hB80, 32'h0);
    chk("post_reset_irq_take", {31'b0, irq_take_o}, 32'h0);

    cyc(3);
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Machine-mode CSR file, next generation: parametrised, fully registered, active-low async reset.
- Adds 64-bit cycle/instret counters, WARL field masking, trap-entry/mret sequencing, interrupt arbitration and registered read with valid pulse.
- Sits beside the execute/writeback stage; serves CSR instructions and the exception unit.

Parameters:
XLEN, 32, data width; only 32 supported.
HART_ID, 0, value returned by mhartid.
MISA_VAL, 32'h40000100, read-only misa (RV32I).
RESET_MTVEC, 32'h00000000, mtvec reset value.
CNT_W, 64, counter width (must be 64).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
csr_req_i  in  1  CSR instruction valid this cycle
csr_op_i  in  3  funct3 of the instruction
csr_addr_i  in  12  CSR address
csr_wdata_i  in  XLEN  rs1 value or zero-extended uimm
csr_src_zero_i  in  1  rs1 index / uimm is zero
csr_rdata_o  out  XLEN  old CSR value, registered
csr_rvalid_o  out  1  one-cycle pulse, rdata valid
csr_illegal_o  out  1  one-cycle pulse with rvalid, access illegal
retire_i  in  1  one instruction retired
trap_i  in  1  take exception/interrupt this cycle
trap_cause_i  in  XLEN  mcause value (bit31 = interrupt)
trap_pc_i  in  XLEN  faulting PC
trap_tval_i  in  XLEN  mtval value
mret_i  in  1  execute mret
irq_ext_i / irq_tim_i / irq_sw_i  in  1 each  level interrupt lines
irq_take_o  out  1  enabled interrupt pending
irq_cause_o  out  XLEN  cause for irq_take_o
trap_vec_o  out  XLEN  trap target PC
mepc_o  out  XLEN  mret target

Behaviour:
- Reset: all outputs 0; mstatus = MPP 2'b11, rest 0; mtvec = RESET_MTVEC; all other CSRs and counters 0.
- Registers: misa, mvendorid(0), marchid(0), mimpid(0), mhartid, mstatus, mtvec, mscratch, mepc, mcause, mtval, mie, mip, mcountinhibit(0x320), mcycle/mcycleh (B00/B80), minstret/minstreth (B02/B82).
- Op decode: op[1:0] 01 = RW, 10 = RS, 11 = RC. op[1:0] = 00 is illegal.
- Write suppression: RS/RC with csr_src_zero_i write nothing. RW always writes.
- Illegal: unknown address; write attempted to address[11:10] = 2'b11; op[1:0] = 00. Illegal access changes no state and returns rdata 0.
- Timing: read and write both commit at the edge after csr_req_i. rdata carries the pre-write value. rvalid and illegal pulse exactly one cycle.
- WARL masks:
  - mstatus: only MIE[3] and MPIE[7] are writable; MPP reads 11.
  - mtvec: bit 1 reads 0.
  - mepc: bits[1:0] read 0.
  - mie: only bits 3, 7 and 11 are writable.
  - mip: read-only.
- mip: MEIP[11], MTIP[7] and MSIP[3] sample the irq lines each cycle (one-cycle latency).
- Counters:
  - mcycle increments every cycle unless mcountinhibit.CY=1.
  - minstret increments on retire_i unless mcountinhibit.IR=1.
  - A CSR write to either half wins over the increment that cycle, for the whole 64-bit counter.
  - Carry propagates from low to high; wrap from 2^64-1 to 0.
- Trap entry (trap_i):
  - mepc <= trap_pc_i & ~3; mcause <= trap_cause_i; mtval <= trap_tval_i.
  - MPIE <= MIE; MIE <= 0.
- mret_i: MIE <= MPIE; MPIE <= 1.
- Priority: trap_i > mret_i > CSR write.
  - A CSR request coincident with trap_i is squashed: no write, no rvalid.
  - A CSR request with mret_i: the CSR write proceeds except to mstatus, which mret owns.
- trap_vec_o (combinational from registers):
  - Default: {mtvec[31:2], 2'b00}.
  - If mtvec[0] = 1 and trap_cause_i[31] = 1: base + 4*cause[4:0].
- irq_take_o = MIE & |(mip & mie). Cause priority: MEI (11) > MSI (3) > MTI (7). irq_cause_o = {1'b1, 27'b0, code}, 0 when none.
- mepc_o = mepc.
- Reset deassertion mid-operation: every register restarts from its reset value; no partial-write residue.

Decomposition:
- csr_pkg: CSR address constants, mstatus/mip bit positions, WARL masks, interrupt cause codes, op encodings.
- Sub-module csr_counter64, instantiated twice: inc_i, inhibit_i, wr_lo_i, wr_hi_i, wdata_i, count_o.

Test Plan:
- Reset, then CSRRW mscratch = 0xDEADBEEF, then CSRRS x0 read → second rdata 0xDEADBEEF, rvalid one cycle, no write on the RS.
- CSRRW to mvendorid (0xF11) and to address 0x7C0 → csr_illegal_o = 1, rdata 0, state unchanged.
- Preload mcycle = 0x00000000_FFFFFFFF via RW to B00, wait 1 cycle → mcycleh = 1, mcycle = 0. Set mcountinhibit = 1 → mcycle frozen.
- mstatus.MIE = 1, then trap_i with cause 2 and pc 0x103 → mepc 0x100, MIE 0, MPIE 1, trap_vec_o = mtvec base. Then mret_i → MIE 1.
- mtvec = 0x101, mie = 0x888, MIE = 1, assert irq_tim_i and irq_ext_i → irq_take_o = 1, irq_cause_o = 0x8000000B; trap with that cause → trap_vec_o = 0x12C.
- CSRRW mscratch together with trap_i → no rvalid, mscratch unchanged. Assert rst_ni low mid-run → all outputs 0 asynchronously.
